demultiplexer_router: RTL

//  1-to-4 routing demultiplexer: inverse of the team's 4:1 multiplexer.
//  - One valid/ready input stream with a 2-bit select.
//  - Each word is steered to one of four output channels, each with its own small FIFO.
//  - Sits between a single producer and four independent consumers; per-channel

---
 rtl/demultiplexer_router_if.sv | 42 ++++
 rtl/demultiplexer_router.sv | 80 ++++++++
 2 files changed

// File: rtl/demultiplexer_router_if.sv
// Stream bundle for demultiplexer_router: one valid/ready input, four valid/ready outputs.
// Optional per-channel statistics ports appear when DEMUX_STAT_EN is defined.
interface demultiplexer_router_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        inx_sel;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [DATA_W-1:0] out_data_0;
    logic [DATA_W-1:0] out_data_1;
    logic [DATA_W-1:0] out_data_2;
    logic [DATA_W-1:0] out_data_3;
`ifdef DEMUX_STAT_EN
    logic [15:0]       stat_cnt_0;
    logic [15:0]       stat_cnt_1;
    logic [15:0]       stat_cnt_2;
    logic [15:0]       stat_cnt_3;

    modport slave (
        input  in_valid, in_data, inx_sel, out_ready,
        output in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3,
        output stat_cnt_0, stat_cnt_1, stat_cnt_2, stat_cnt_3
    );
    modport master (
        output in_valid, in_data, inx_sel, out_ready,
        input  in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3,
        input  stat_cnt_0, stat_cnt_1, stat_cnt_2, stat_cnt_3
    );
`else
    modport slave (
        input  in_valid, in_data, inx_sel, out_ready,
        output in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3
    );
    modport master (
        output in_valid, in_data, inx_sel, out_ready,
        input  in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3
    );
`endif
endinterface

// File: rtl/demultiplexer_router.sv
// 1-to-4 routing demultiplexer with a small FIFO per output channel.
// Define DEMUX_STAT_EN to add saturating per-channel accepted-word counters.
module demultiplexer_router #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demultiplexer_router_if.slave bus
);
    localparam int NCH = 4;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    logic [NCH-1:0]             w_full;
    logic [NCH-1:0]             w_vld;
    logic [NCH-1:0]             w_push;
    logic [NCH-1:0][DATA_W-1:0] w_head;
`ifdef DEMUX_STAT_EN
    logic [NCH-1:0][15:0]       w_stat;
`endif

    // A full channel refuses input even if it pops this cycle: no full pass-through.
    assign bus.in_ready = ~w_full[bus.inx_sel];

    for (genvar k = 0; k < NCH; k++) begin : gen_ch
        logic [CW-1:0]                 r_cnt;
        logic [PW-1:0]                 r_wr;
        logic [PW-1:0]                 r_rd;
        logic [DEPTH-1:0][DATA_W-1:0]  r_mem;
        logic                          w_pop;

        assign w_full[k] = (r_cnt == CW'(DEPTH));
        assign w_vld[k]  = (r_cnt != '0);
        assign w_push[k] = bus.in_valid & ~w_full[k] & (bus.inx_sel == 2'(k));
        assign w_pop     = w_vld[k] & bus.out_ready[k];
        assign w_head[k] = r_mem[r_rd];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_wr  <= '0;
                r_rd  <= '0;
                r_mem <= '0;
            end else begin
                if (w_push[k]) begin
                    r_mem[r_wr] <= bus.in_data;
                    r_wr        <= r_wr + PW'(1);
                end
                if (w_pop) r_rd <= r_rd + PW'(1);
                case ({w_push[k], w_pop})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

`ifdef DEMUX_STAT_EN
        logic [15:0] r_stat;
        always_ff @(posedge clk) begin
            if (!rst_n)                               r_stat <= '0;
            else if (w_push[k] && r_stat != 16'hFFFF) r_stat <= r_stat + 16'd1;
        end
        assign w_stat[k] = r_stat;
`endif
    end

    assign bus.out_valid  = w_vld;
    assign bus.out_data_0 = w_head[0];
    assign bus.out_data_1 = w_head[1];
    assign bus.out_data_2 = w_head[2];
    assign bus.out_data_3 = w_head[3];
`ifdef DEMUX_STAT_EN
    assign bus.stat_cnt_0 = w_stat[0];
    assign bus.stat_cnt_1 = w_stat[1];
    assign bus.stat_cnt_2 = w_stat[2];
    assign bus.stat_cnt_3 = w_stat[3];
`endif
endmodule
